route_requester: RTL
====================

ROUTE_REQUESTER -- requirements
Module: route_requester

Interface
REQ-001 SHALL have parameter DATA_W, default 8, packet width (>= 4).
REQ-002 SHALL have parameter X_ID, default 1, this router's 2-bit X coordinate.
REQ-003 SHALL have parameter Y_ID, default 1, this router's 2-bit Y coordinate.
REQ-004 SHALL have parameter DEPTH, default 4, FIFO entries (power of 2, >= 2).
REQ-005 SHALL have parameter STARVE_LIM, default 8, retry count that raises starved (1..15).
REQ-006 SHALL have port clk  input  1  clock, rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port enable  input  1  advance-enable; all state updates gated by it.
REQ-009 SHALL have port in_valid  input  1  upstream packet offered.
REQ-010 SHALL have port in_pkt  input  DATA_W  packet; [DATA_W-1:DATA_W-2] dest X, [DATA_W-3:DATA_W-4] dest Y.
REQ-011 SHALL have port in_ready  output  1  FIFO can accept.
REQ-012 SHALL have port dout  output  2  head direction to arbiter: 00 NONE, 01 X, 10 Y, 11 LOCAL.
REQ-013 SHALL have port fail  input  1  this port's arbiter fail bit for the head presented this cycle.
REQ-014 SHALL have port out_valid  output  1  registered one-cycle pulse: packet launched.
REQ-015 SHALL have port out_pkt  output  DATA_W  launched packet, held until next launch.
REQ-016 SHALL have port retry_cnt  output  4  consecutive failed attempts of current head, saturating at 15.
REQ-017 SHALL have port starved  output  1  retry_cnt >= STARVE_LIM.

Function
REQ-018 SHALL store packets in a DEPTH-entry circular FIFO with read/write pointers and an occupancy count of width log2(DEPTH)+1; pointers wrap modulo DEPTH.
REQ-019 SHALL drive in_ready = (count != DEPTH), combinationally from registered state.
REQ-020 SHALL accept a push on a rising edge when enable && in_valid && in_ready.
REQ-021 SHALL derive dout combinationally from the head: empty -> 00; dest X != X_ID -> 01; else dest Y != Y_ID -> 10; else 11 (X-first dimension order).
REQ-022 SHALL, on a rising edge with enable=1, dout!=00 and fail=0, pop the head, load out_pkt with it, pulse out_valid=1, clear retry_cnt.
REQ-023 SHALL, on a rising edge with enable=1, dout!=00 and fail=1, keep the head, keep dout unchanged, increment retry_cnt saturating at 15, out_valid=0.
REQ-024 SHALL ignore fail when empty (dout=00): no pop, retry_cnt stays 0.
REQ-025 SHALL, when enable=0, hold all state (no push, no pop, retry_cnt held) and drive out_valid=0 on the following edge.
REQ-026 SHALL allow simultaneous push and pop in one cycle when not full (count unchanged); when full, in_ready=0 so no push even if popping that cycle.
REQ-027 SHALL not present a packet pushed this cycle on dout before the next cycle (zero bypass; FIFO latency >= 1 cycle).
REQ-028 SHALL drive starved combinationally from retry_cnt.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously clear pointers, count, out_valid, out_pkt (0), retry_cnt (0); dout=00, in_ready=1, starved=0.
REQ-030 SHALL discard all buffered packets on reset asserted mid-operation; first edge after release behaves as from empty.

Verification (DATA_W=8, X_ID=1, Y_ID=1, DEPTH=4, STARVE_LIM=8)
REQ-031 SHALL cover: reset released, in_valid=0 -> dout=00, in_ready=1, out_valid=0, retry_cnt=0.
REQ-032 SHALL cover: push 8'hC5, fail=0 -> next cycle dout=01; following edge out_valid=1, out_pkt=8'hC5, dout=00.
REQ-033 SHALL cover: push 8'h45 then 8'h55 -> dout=10 for 8'h45, after its launch dout=11 for 8'h55.
REQ-034 SHALL cover: head 8'hC5 with fail=1 for 9 cycles -> dout stays 01, retry_cnt=9, starved=1; then fail=0 -> out_pkt=8'hC5, retry_cnt=0, starved=0.
REQ-035 SHALL cover: fail=1, push 8'h11,8'h22,8'h33,8'h44,8'h66 -> in_ready=0 after 4th, 8'h66 dropped; fail=0 -> launched order 11,22,33,44.
REQ-036 SHALL cover: enable=0 with head present, fail=0 -> no launch; rst_n pulsed low mid-burst -> dout=00, count 0, out_pkt=0 immediately.

Source files
------------

// File: rtl/route_requester.sv
// route_requester: input-port requester for a 2D mesh router.
// Buffers packets in a small circular FIFO and uses X-first dimension-order
// routing to compute the head's direction. When the arbiter does not grant
// the head (fail), the head is retried and the attempts are counted.
module route_requester #(
   parameter int DATA_W     = 8,
   parameter int X_ID       = 1,
   parameter int Y_ID       = 1,
   parameter int DEPTH      = 4,
   parameter int STARVE_LIM = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_pkt,
   output logic              in_ready,
   output logic [1:0]        dout,
   input  logic              fail,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_pkt,
   output logic [3:0]        retry_cnt,
   output logic              starved
);

   localparam int             AW         = $clog2(DEPTH);
   localparam logic [AW:0]    C_FULL     = (AW+1)'(DEPTH);
   localparam logic [AW:0]    C_CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0]  C_PTR_ONE  = AW'(1);
   localparam logic [1:0]     C_X_ID     = 2'(X_ID);
   localparam logic [1:0]     C_Y_ID     = 2'(Y_ID);
   localparam logic [3:0]     C_STARVE   = 4'(STARVE_LIM);

   localparam logic [1:0]     DIR_NONE   = 2'b00;
   localparam logic [1:0]     DIR_X      = 2'b01;
   localparam logic [1:0]     DIR_Y      = 2'b10;
   localparam logic [1:0]     DIR_LOCAL  = 2'b11;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_rd_ptr;
   logic [AW-1:0]     r_wr_ptr;
   logic [AW:0]       r_count;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_pkt;
   logic [3:0]        r_retry_cnt;

   logic              w_empty;
   logic [DATA_W-1:0] w_head;
   logic [1:0]        w_dest_x;
   logic [1:0]        w_dest_y;
   logic [1:0]        w_dir;
   logic              w_push;
   logic              w_pop;

   assign w_empty   = (r_count == '0);
   assign w_head    = r_mem[r_rd_ptr];
   assign w_dest_x  = w_head[DATA_W-1:DATA_W-2];
   assign w_dest_y  = w_head[DATA_W-3:DATA_W-4];

   // A push needs room; a launch needs a head and a grant (no fail).
   assign w_push    = enable && in_valid && in_ready;
   assign w_pop     = enable && (w_dir != DIR_NONE) && !fail;

   assign in_ready  = (r_count != C_FULL);
   assign dout      = w_dir;
   assign out_valid = r_out_valid;
   assign out_pkt   = r_out_pkt;
   assign retry_cnt = r_retry_cnt;
   assign starved   = (r_retry_cnt >= C_STARVE);

   // X-first routing decision for the current head.
   always_comb begin
      // NOTE: default assignment first so every path drives w_dir (no latch).
      w_dir = DIR_NONE;
      if (!w_empty) begin
         if (w_dest_x != C_X_ID)      w_dir = DIR_X;
         else if (w_dest_y != C_Y_ID) w_dir = DIR_Y;
         else                         w_dir = DIR_LOCAL;
      end
   end

   // Packet storage write port.
   // NOTE: the storage array is deliberately not reset; emptiness is tracked
   // by r_count, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= in_pkt;
   end

   // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments for all sequential state.
      if (!rst_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + C_CNT_ONE;
            2'b01:   r_count <= r_count - C_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Launch register: one-cycle valid pulse, packet held until next launch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_pkt   <= '0;
      end else begin
         r_out_valid <= w_pop;
         if (w_pop) r_out_pkt <= w_head;
      end
   end

   // Consecutive failed attempts of the current head, saturating at 15.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_retry_cnt <= '0;
      end else if (enable && (w_dir != DIR_NONE)) begin
         if (fail) begin
            if (r_retry_cnt != 4'hF) r_retry_cnt <= r_retry_cnt + 4'd1;
         end else begin
            r_retry_cnt <= '0;
         end
      end
   end

endmodule
